// File: rtl/updn_counter_if.sv
// Control and status bundle for updn_counter.
// The sat signal exists only when UPDN_SAT_EN is defined.
interface updn_counter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEPW = 4
);
    logic             en;
    logic             dir;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [STEPW-1:0] step;
`ifdef UPDN_SAT_EN
    logic             sat;
`endif
    logic             clr_flags;
    logic [WIDTH-1:0] q;
    logic [1:0]       state;
    logic             tc;
    logic             ovf;
    logic             unf;

    // Master drives the controls and observes the count.
    modport master (
        output en, dir, ld, ld_val, step,
`ifdef UPDN_SAT_EN
        output sat,
`endif
        output clr_flags,
        input  q, state, tc, ovf, unf
    );

    // Slave is the counter itself.
    modport slave (
        input  en, dir, ld, ld_val, step,
`ifdef UPDN_SAT_EN
        input  sat,
`endif
        input  clr_flags,
        output q, state, tc, ovf, unf
    );
endinterface

// File: rtl/updn_counter.sv
// Modulo-N up/down counter with programmable step, parallel load and sticky flags.
// Saturate mode (sat input) is built only when UPDN_SAT_EN is defined; otherwise it always wraps.
module updn_counter #(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter int unsigned     STEPW   = 4
) (
    input logic           clk,
    input logic           rst_n,
    updn_counter_if.slave bus
);
    // One extra bit so q + step and q + MODULUS never overflow.
    localparam int unsigned XW = WIDTH + 1;

    localparam logic [XW-1:0]    MOD  = XW'(MODULUS);
    localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MODULUS - 64'd1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_LOAD = 2'd3
    } op_e;

    op_e              state_r, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             tc_r, tc_nxt;
    logic             ovf_r, ovf_nxt;
    logic             unf_r, unf_nxt;

    logic [XW-1:0]    q_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    sum_x;
    logic             up_cross;
    logic             dn_cross;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] up_plain;
    logic [WIDTH-1:0] dn_wrap;
    logic [WIDTH-1:0] dn_plain;
    logic [WIDTH-1:0] ld_clamped;
    logic             ovf_set;
    logic             unf_set;

    // Arithmetic candidates for every operation, evaluated each cycle.
    always_comb begin
        q_x        = {1'b0, q_r};
        step_x     = XW'(bus.step);
        sum_x      = q_x + step_x;
        up_cross   = (sum_x >= MOD);
        dn_cross   = (q_x < step_x);
        up_wrap    = WIDTH'(sum_x - MOD);
        up_plain   = WIDTH'(sum_x);
        dn_wrap    = WIDTH'(q_x + MOD - step_x);
        dn_plain   = WIDTH'(q_x - step_x);
        ld_clamped = ({1'b0, bus.ld_val} >= MOD) ? MAXQ : bus.ld_val;
    end

    // Operation select and next-state values; ld beats en, up beats down.
    always_comb begin
        state_nxt = ST_HOLD;
        q_nxt     = q_r;
        tc_nxt    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (bus.ld) begin
            state_nxt = ST_LOAD;
            q_nxt     = ld_clamped;
        end else if (bus.en && bus.dir) begin
            state_nxt = ST_UP;
            if (up_cross) begin
                tc_nxt  = 1'b1;
                ovf_set = 1'b1;
`ifdef UPDN_SAT_EN
                q_nxt   = bus.sat ? MAXQ : up_wrap;
`else
                q_nxt   = up_wrap;
`endif
            end else begin
                q_nxt = up_plain;
            end
        end else if (bus.en) begin
            state_nxt = ST_DOWN;
            if (dn_cross) begin
                tc_nxt  = 1'b1;
                unf_set = 1'b1;
`ifdef UPDN_SAT_EN
                q_nxt   = bus.sat ? '0 : dn_wrap;
`else
                q_nxt   = dn_wrap;
`endif
            end else begin
                q_nxt = dn_plain;
            end
        end

        // A set on the same edge as a clear wins.
        ovf_nxt = (ovf_r & ~bus.clr_flags) | ovf_set;
        unf_nxt = (unf_r & ~bus.clr_flags) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_HOLD;
            q_r     <= '0;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            q_r     <= q_nxt;
            tc_r    <= tc_nxt;
            ovf_r   <= ovf_nxt;
            unf_r   <= unf_nxt;
        end
    end

    assign bus.q     = q_r;
    assign bus.state = state_r;
    assign bus.tc    = tc_r;
    assign bus.ovf   = ovf_r;
    assign bus.unf   = unf_r;

endmodule

// File: tb/tb_updn_counter.sv
// Bench for updn_counter (WIDTH=4, MODULUS=10): directed plan steps then random traffic
// against an integer reference model. Saturate steps run only when UPDN_SAT_EN is defined.
module tb_updn_counter;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned STEPW = 4;
    localparam int          MODV  = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_q, m_state;
    bit m_tc, m_ovf, m_unf;

    updn_counter_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

    updn_counter #(
        .WIDTH  (WIDTH),
        .MODULUS(64'd10),
        .STEPW  (STEPW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},     32'(bus.q),     32'(m_q));
        chk({tag, ".state"}, 32'(bus.state), 32'(m_state));
        chk({tag, ".tc"},    32'(bus.tc),    32'(m_tc));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.unf),   32'(m_unf));
    endtask

    task automatic drive(input bit ld, input int ld_val, input bit en, input bit dir,
                         input int step, input bit clr, input bit sat);
        bus.ld        = ld;
        bus.ld_val    = WIDTH'(ld_val);
        bus.en        = en;
        bus.dir       = dir;
        bus.step      = STEPW'(step);
        bus.clr_flags = clr;
`ifdef UPDN_SAT_EN
        bus.sat       = sat;
`else
        if (sat) $display("note: sat requested but saturate mode not built");
`endif
    endtask

    // Spec-level behaviour: integer arithmetic on the count range 0..MODV-1.
    task automatic model_edge();
        bit satm, nov, nun;
        int s;
`ifdef UPDN_SAT_EN
        satm = bus.sat;
`else
        satm = 1'b0;
`endif
        if (!rst_n) begin
            m_q = 0; m_state = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        nov  = 0;
        nun  = 0;
        m_tc = 0;
        if (bus.ld) begin
            m_state = 3;
            m_q     = (int'(bus.ld_val) >= MODV) ? MODV - 1 : int'(bus.ld_val);
        end else if (bus.en && bus.dir) begin
            m_state = 1;
            s = m_q + int'(bus.step);
            if (s >= MODV) begin
                m_tc = 1; nov = 1;
                m_q  = satm ? MODV - 1 : s - MODV;
            end else m_q = s;
        end else if (bus.en) begin
            m_state = 2;
            if (m_q < int'(bus.step)) begin
                m_tc = 1; nun = 1;
                m_q  = satm ? 0 : m_q + MODV - int'(bus.step);
            end else m_q = m_q - int'(bus.step);
        end else begin
            m_state = 0;
        end
        m_ovf = nov | (m_ovf & !bus.clr_flags);
        m_unf = nun | (m_unf & !bus.clr_flags);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        m_q = 0; m_state = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset for two cycles
        cycle("rst0");
        cycle("rst1");
        chk("rst_q", 32'(bus.q), 32'd0);

        // Load with clamp: 12 -> 9
        rst_n = 1'b1;
        drive(1, 12, 0, 0, 0, 0, 0);
        cycle("ld12");
        chk("ld_clamp_q", 32'(bus.q), 32'd9);
        chk("ld_clamp_state", 32'(bus.state), 32'd3);

        // Up-wrap 8 + 3 -> 1, then ovf sticks over 5 holds
        drive(1, 8, 0, 0, 0, 0, 0);
        cycle("ld8");
        drive(0, 0, 1, 1, 3, 0, 0);
        cycle("upwrap");
        chk("upwrap_q", 32'(bus.q), 32'd1);
        chk("upwrap_tc", 32'(bus.tc), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("hold_ovf");
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);
        chk("tc_dropped", 32'(bus.tc), 32'd0);

        // Down-wrap 1 - 2 -> 9
        drive(1, 1, 0, 0, 0, 0, 0);
        cycle("ld1");
        drive(0, 0, 1, 0, 2, 0, 0);
        cycle("dnwrap");
        chk("dnwrap_q", 32'(bus.q), 32'd9);
        chk("dnwrap_unf", 32'(bus.unf), 32'd1);
        // Clear coinciding with another down-wrap: set wins for unf
        drive(1, 0, 0, 0, 0, 0, 0);
        cycle("ld0");
        drive(0, 0, 1, 0, 2, 1, 0);
        cycle("clr_and_wrap");
        chk("setwins_unf", 32'(bus.unf), 32'd1);
        chk("setwins_q", 32'(bus.q), 32'd8);
        drive(0, 0, 0, 0, 0, 1, 0);
        cycle("clr_alone");
        chk("clr_unf", 32'(bus.unf), 32'd0);

`ifdef UPDN_SAT_EN
        drive(1, 7, 0, 0, 0, 0, 1);
        cycle("ld7");
        drive(0, 0, 1, 1, 5, 0, 1);
        cycle("sat_up");
        chk("sat_up_q", 32'(bus.q), 32'd9);
        drive(1, 2, 0, 0, 0, 0, 1);
        cycle("ld2");
        drive(0, 0, 1, 0, 4, 0, 1);
        cycle("sat_dn");
        chk("sat_dn_q", 32'(bus.q), 32'd0);
`endif

        // ld beats en; then mid-count reset
        drive(1, 4, 1, 1, 1, 0, 0);
        cycle("prio");
        chk("prio_state", 32'(bus.state), 32'd3);
        drive(0, 0, 1, 1, 1, 0, 0);
        cycle("up5");
        cycle("up6");
        rst_n = 1'b0;
        cycle("midrst");
        chk("midrst_q", 32'(bus.q), 32'd0);
        rst_n = 1'b1;

        // Zero step reports UP without moving
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle("ld5");
        drive(0, 0, 1, 1, 0, 0, 0);
        cycle("step0");
        chk("step0_state", 32'(bus.state), 32'd1);
        chk("step0_q", 32'(bus.q), 32'd5);

        // Random traffic; step kept below MODULUS
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, 1'($urandom),
                  int'($urandom_range(0, MODV - 1)), $urandom_range(0, 7) == 0,
`ifdef UPDN_SAT_EN
                  1'($urandom)
`else
                  1'b0
`endif
                  );
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
